// File: rtl/sha256_padder_if.sv
// Host byte stream plus core block handshake seen by the sha256 message padder.
// master = padder side, slave = host/core side.
interface sha256_padder_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_end;
  logic         in_ready;
  logic [511:0] block;
  logic         start;
  logic         first_block;
  logic         last_block;
  logic         finish;
  logic         msg_done;

  modport master (
    input  in_data, in_valid, in_end, finish,
    output in_ready, block, start, first_block, last_block, msg_done
  );

  modport slave (
    output in_data, in_valid, in_end, finish,
    input  in_ready, block, start, first_block, last_block, msg_done
  );
endinterface

// File: rtl/sha256_padder.sv
// Builds FIPS 180-4 padded 512-bit blocks from a byte stream and hands them to the
// sha256 core over a start/finish handshake.
//
// state | meaning
// FILL  | accepting message bytes / end strobe into the current block
// PAD   | write 0x80, zero fill and (if it fits) the bit length
// LEN   | build a trailing block holding only the bit length
// SEND  | one-cycle start pulse to the core
// WAIT  | hold the block until the core reports finish
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input logic            clock,
  input logic            reset,
  sha256_padder_if.master bus
);
  typedef enum logic [2:0] {FILL, PAD, LEN, SEND, WAIT} state_e;

  state_e           state_q, state_d;
  logic [5:0]       byte_idx_q, byte_idx_d;
  logic [LEN_W-1:0] bit_len_q, bit_len_d;
  logic [511:0]     block_q, block_d;
  logic             first_block_q, first_block_d;
  logic             last_block_q, last_block_d;
  logic             msg_done_q, msg_done_d;
  logic             end_pend_q, end_pend_d;
  logic             len_pend_q, len_pend_d;
  logic             first_flag_q, first_flag_d;
  logic             in_ready;
  logic             take_byte;
  logic             take_end;
  logic [63:0]      len64;

  assign in_ready  = (state_q == FILL) && !reset;
  assign take_byte = bus.in_valid && in_ready;
  assign take_end  = bus.in_end && in_ready;
  assign len64     = 64'(bit_len_q);

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    bit_len_d     = bit_len_q;
    block_d       = block_q;
    first_block_d = first_block_q;
    last_block_d  = last_block_q;
    msg_done_d    = 1'b0;
    end_pend_d    = end_pend_q;
    len_pend_d    = len_pend_q;
    first_flag_d  = first_flag_q;

    case (state_q)
      FILL: begin
        if (take_byte) begin
          for (int i = 0; i < 64; i++) begin
            if (6'(i) == byte_idx_q) block_d[511-8*i -: 8] = bus.in_data;
          end
          byte_idx_d = byte_idx_q + 6'd1;
          bit_len_d  = bit_len_q + LEN_W'(8);
          // A full block goes out first; a coincident end is padded afterwards.
          if (byte_idx_q == 6'd63) begin
            state_d      = SEND;
            last_block_d = 1'b0;
            end_pend_d   = take_end;
          end else if (take_end) begin
            state_d = PAD;
          end
        end else if (take_end) begin
          state_d = PAD;
        end
      end

      PAD: begin
        for (int i = 0; i < 64; i++) begin
          if (6'(i) == byte_idx_q)     block_d[511-8*i -: 8] = 8'h80;
          else if (6'(i) > byte_idx_q) block_d[511-8*i -: 8] = 8'h00;
        end
        if (byte_idx_q <= 6'd55) begin
          block_d[63:0] = len64;
          last_block_d  = 1'b1;
        end else begin
          len_pend_d   = 1'b1;
          last_block_d = 1'b0;
        end
        state_d = SEND;
      end

      LEN: begin
        block_d      = {448'd0, len64};
        last_block_d = 1'b1;
        len_pend_d   = 1'b0;
        state_d      = SEND;
      end

      SEND: begin
        first_flag_d = 1'b0;
        state_d      = WAIT;
      end

      WAIT: begin
        if (bus.finish) begin
          if (last_block_q) begin
            msg_done_d   = 1'b1;
            bit_len_d    = '0;
            byte_idx_d   = '0;
            block_d      = '0;
            first_flag_d = 1'b1;
            state_d      = FILL;
          end else if (len_pend_q) begin
            state_d = LEN;
          end else if (end_pend_q) begin
            end_pend_d = 1'b0;
            byte_idx_d = '0;
            block_d    = '0;
            state_d    = PAD;
          end else begin
            byte_idx_d = '0;
            block_d    = '0;
            state_d    = FILL;
          end
        end
      end

      default: state_d = FILL;
    endcase

    // first_block must already be valid in the SEND cycle alongside start.
    if (state_d == SEND) first_block_d = first_flag_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FILL;
      byte_idx_q    <= '0;
      bit_len_q     <= '0;
      block_q       <= '0;
      first_block_q <= 1'b0;
      last_block_q  <= 1'b0;
      msg_done_q    <= 1'b0;
      end_pend_q    <= 1'b0;
      len_pend_q    <= 1'b0;
      first_flag_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      bit_len_q     <= bit_len_d;
      block_q       <= block_d;
      first_block_q <= first_block_d;
      last_block_q  <= last_block_d;
      msg_done_q    <= msg_done_d;
      end_pend_q    <= end_pend_d;
      len_pend_q    <= len_pend_d;
      first_flag_q  <= first_flag_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.block       = block_q;
  assign bus.start       = (state_q == SEND);
  assign bus.first_block = first_block_q;
  assign bus.last_block  = last_block_q;
  assign bus.msg_done    = msg_done_q;
endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known messages with hand-built padded blocks,
// handshake timing, delayed finish and reset during WAIT.
module tb_sha256_padder;
  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  sha256_padder_if bus ();

  sha256_padder #(.LEN_W(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: all 0x61; mode 1: byte i = i; mode 2: 0x61 + i ("abc"...)
  task automatic feed(input int n, input int mode, input bit end_on_last);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (mode == 0) ? 8'h61 : (mode == 1) ? 8'(i) : 8'(8'h61 + 8'(i));
      bus.in_end   = end_on_last && (i == n - 1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_end   = 1'b0;
    if (!end_on_last) begin
      bus.in_end = 1'b1;
      step();
      bus.in_end = 1'b0;
    end
  endtask

  task automatic do_block(input string tag, input logic [511:0] eb, input bit ef,
                          input bit el, input int dly);
    bit           got;
    bit           stable;
    int           extra;
    logic [511:0] snap;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.start === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_start_seen"}, 512'(got), 512'd1);
    chk({tag, "_block"}, bus.block, eb);
    chk({tag, "_first"}, 512'(bus.first_block), 512'(ef));
    chk({tag, "_last"}, 512'(bus.last_block), 512'(el));
    snap = bus.block;
    step();
    chk({tag, "_start_pulse"}, 512'(bus.start), 512'd0);
    stable = 1'b1;
    extra  = 0;
    for (int c = 0; c < dly; c++) begin
      if (bus.block !== snap || bus.in_ready !== 1'b0) stable = 1'b0;
      if (bus.start === 1'b1) extra++;
      step();
    end
    if (dly > 0) begin
      chk({tag, "_hold_stable"}, 512'(stable), 512'd1);
      chk({tag, "_no_restart"}, 512'(extra), 512'd0);
    end
    bus.finish = 1'b1;
    step();
    bus.finish = 1'b0;
    chk({tag, "_msg_done"}, 512'(bus.msg_done), 512'(el));
    if (el) begin
      chk({tag, "_ready_after"}, 512'(bus.in_ready), 512'd1);
      step();
      chk({tag, "_msg_done_pulse"}, 512'(bus.msg_done), 512'd0);
    end
  endtask

  initial begin
    logic [511:0] e64;
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_end   = 1'b0;
    bus.finish   = 1'b0;
    step();
    step();
    chk("rst_in_ready", 512'(bus.in_ready), 512'd0);
    chk("rst_start", 512'(bus.start), 512'd0);
    chk("rst_msg_done", 512'(bus.msg_done), 512'd0);
    chk("rst_block", bus.block, 512'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", 512'(bus.in_ready), 512'd1);

    // "abc"
    feed(3, 2, 1'b0);
    chk("abc_lat_pad", 512'(bus.start), 512'd0);
    step();
    chk("abc_lat_send", 512'(bus.start), 512'd1);
    do_block("abc", {24'h616263, 8'h80, 416'd0, 64'h18}, 1'b1, 1'b1, 0);

    // empty message
    feed(0, 0, 1'b0);
    do_block("empty", {8'h80, 440'd0, 64'h0}, 1'b1, 1'b1, 0);

    // 55 bytes fit in one block; finish held off 100 cycles
    feed(55, 0, 1'b0);
    do_block("b55", {{55{8'h61}}, 8'h80, 64'h1B8}, 1'b1, 1'b1, 100);

    // 56 bytes spill the length into a second block
    feed(56, 0, 1'b0);
    do_block("b56_1", {{56{8'h61}}, 8'h80, 56'd0}, 1'b1, 1'b0, 3);
    do_block("b56_2", {448'd0, 64'h1C0}, 1'b0, 1'b1, 0);

    // 64 bytes with end on the last byte
    e64 = '0;
    for (int i = 0; i < 64; i++) e64[511-8*i -: 8] = 8'(i);
    feed(64, 1, 1'b1);
    do_block("b64_1", e64, 1'b1, 1'b0, 2);
    do_block("b64_2", {8'h80, 440'd0, 64'h200}, 1'b0, 1'b1, 0);

    // reset while waiting for finish
    feed(3, 2, 1'b0);
    step();
    step();
    chk("rw_in_wait_ready", 512'(bus.in_ready), 512'd0);
    reset = 1'b1;
    step();
    chk("rw_ready_in_reset", 512'(bus.in_ready), 512'd0);
    chk("rw_block_cleared", bus.block, 512'd0);
    reset = 1'b0;
    #1;
    chk("rw_ready_after", 512'(bus.in_ready), 512'd1);
    bus.finish = 1'b1;
    step();
    bus.finish = 1'b0;
    chk("rw_late_finish_done", 512'(bus.msg_done), 512'd0);
    chk("rw_late_finish_start", 512'(bus.start), 512'd0);
    step();
    chk("rw_late_finish_done2", 512'(bus.msg_done), 512'd0);

    // padder still works after the aborted message
    feed(0, 0, 1'b0);
    do_block("post_rst", {8'h80, 440'd0, 64'h0}, 1'b1, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
